// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : aes_pkg
//  Brief    : Shared constants and state encoding for the AES-128 sequencer.
//  Revision : 1.0
// ============================================================================
package aes_pkg;

    localparam int NR    = 10;
    localparam int IDX_W = 4;

    localparam logic [IDX_W-1:0] IDX_ZERO = '0;
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NR);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_KEYEXP = 2'd1,
        ST_ROUND  = 2'd2,
        ST_DONE   = 2'd3
    } aes_state_e;

endpackage
`default_nettype wire

// File: rtl/aes_key_cache.sv
`default_nettype none
// ============================================================================
//  Module   : aes_key_cache
//  Brief    : Single-entry cache of the last fully expanded AES-128 key.
//  Revision : 1.0
// ============================================================================
module aes_key_cache (
    input  logic         clk,
    input  logic         resetn,
    input  logic [127:0] i_key,
    input  logic         i_load,
    input  logic         i_commit,
    input  logic         i_flush,
    output logic         o_hit
);

    logic [127:0] r_key;
    logic         r_valid;

    // A new miss invalidates the entry until its expansion completes; flush beats commit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_key   <= '0;
            r_valid <= 1'b0;
        end else begin
            if (i_load) begin
                r_key <= i_key;
            end
            if (i_flush || i_load) begin
                r_valid <= 1'b0;
            end else if (i_commit) begin
                r_valid <= 1'b1;
            end
        end
    end

    assign o_hit = r_valid && !i_flush && (i_key == r_key);

endmodule
`default_nettype wire

// File: rtl/aes128_seq.sv
`default_nettype none
// ============================================================================
//  Module   : aes128_seq
//  Brief    : AES-128 round/key-expansion sequencer with optional key cache
//             (define AES_KEY_CACHE_EN to enable the cache and key_flush).
//  Revision : 1.0
// ============================================================================
module aes128_seq
    import aes_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [127:0]         in_key,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef AES_KEY_CACHE_EN
    input  logic                 key_flush,
`endif
    output logic                 dp_load,
    output logic                 dp_key_step,
    output logic                 dp_round_en,
    output logic [IDX_W-1:0]     dp_idx,
    output logic                 dp_last_round,
    output logic                 busy,
    output logic                 cache_hit,
    output logic [CNT_W-1:0]     blk_cnt
);

    aes_state_e       r_state;
    aes_state_e       w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [CNT_W-1:0] r_blk_cnt;
    logic             w_accept;
    logic             w_hit;
    logic             w_handshake;

    assign in_ready    = (r_state == ST_IDLE);
    assign w_accept    = in_valid && in_ready;
    assign w_handshake = (r_state == ST_DONE) && out_ready;

`ifdef AES_KEY_CACHE_EN
    aes_key_cache u_key_cache (
        .clk      (clk),
        .resetn   (resetn),
        .i_key    (in_key),
        .i_load   (w_accept && !w_hit),
        .i_commit ((r_state == ST_KEYEXP) && (r_idx == IDX_LAST)),
        .i_flush  (key_flush),
        .o_hit    (w_hit)
    );
`else
    logic w_unused_key;
    assign w_unused_key = ^in_key;
    assign w_hit        = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_idx     <= IDX_ZERO;
            r_blk_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if (w_handshake) begin
                r_blk_cnt <= r_blk_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_idx_nxt   = IDX_ONE;
                    w_state_nxt = w_hit ? ST_ROUND : ST_KEYEXP;
                end
            end
            ST_KEYEXP: begin
                if (r_idx == IDX_LAST) begin
                    w_idx_nxt   = IDX_ONE;
                    w_state_nxt = ST_ROUND;
                end else begin
                    w_idx_nxt = r_idx + IDX_ONE;
                end
            end
            ST_ROUND: begin
                if (r_idx == IDX_LAST) begin
                    w_idx_nxt   = IDX_ZERO;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_idx_nxt = r_idx + IDX_ONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_idx_nxt   = IDX_ZERO;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign dp_load       = w_accept;
    assign dp_key_step   = (r_state == ST_KEYEXP);
    assign dp_round_en   = (r_state == ST_ROUND);
    assign dp_idx        = (dp_key_step || dp_round_en) ? r_idx : IDX_ZERO;
    assign dp_last_round = dp_round_en && (r_idx == IDX_LAST);
    assign out_valid     = (r_state == ST_DONE);
    assign busy          = !in_ready;
    assign cache_hit     = w_accept && w_hit;
    assign blk_cnt       = r_blk_cnt;

endmodule
`default_nettype wire

// File: tb/tb_aes128_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes128_seq
//  Brief    : Directed self-checking bench for aes128_seq (CNT_W = 4).
//  Revision : 1.0
// ============================================================================
module tb_aes128_seq;

    localparam int CNT_W = 4;

`ifdef AES_KEY_CACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    logic             clk;
    logic             resetn;
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     in_key;
    logic             out_valid;
    logic             out_ready;
    logic             key_flush;
    logic             dp_load;
    logic             dp_key_step;
    logic             dp_round_en;
    logic [3:0]       dp_idx;
    logic             dp_last_round;
    logic             busy;
    logic             cache_hit;
    logic [CNT_W-1:0] blk_cnt;

    int               n_tests;
    int               n_fail;
    logic [CNT_W-1:0] exp_cnt;

    aes128_seq #(.CNT_W(CNT_W)) u_dut (
        .clk           (clk),
        .resetn        (resetn),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_key        (in_key),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
`ifdef AES_KEY_CACHE_EN
        .key_flush     (key_flush),
`endif
        .dp_load       (dp_load),
        .dp_key_step   (dp_key_step),
        .dp_round_en   (dp_round_en),
        .dp_idx        (dp_idx),
        .dp_last_round (dp_last_round),
        .busy          (busy),
        .cache_hit     (cache_hit),
        .blk_cnt       (blk_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_check(input string tag);
        check(tag, {in_ready, out_valid, dp_load, dp_key_step, dp_round_en, dp_idx,
                    dp_last_round, busy, cache_hit, blk_cnt},
                   {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, exp_cnt});
    endtask

    // One block: accept, processing cycles against a latency model, DONE hold, handshake.
    task automatic run_block(input logic [127:0] key, input bit flush, input bit exp_hit,
                             input int hold, input bit noise, input int flush_k);
        int         lat;
        int         r;
        logic       e_ks;
        logic       e_rd;
        logic       e_last;
        logic [3:0] e_idx;
        lat = exp_hit ? 11 : 21;
        @(negedge clk);
        in_valid  = 1'b1;
        in_key    = key;
        key_flush = flush;
        out_ready = noise;
        #1;
        check("accept", {in_ready, dp_load, cache_hit, busy, dp_idx},
                        {1'b1, 1'b1, exp_hit, 1'b0, 4'd0});
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            in_valid  = noise;
            in_key    = noise ? ~key : key;
            out_ready = noise;
            key_flush = (k == flush_k);
            #1;
            r      = exp_hit ? k : k - 10;
            e_ks   = !exp_hit && (k <= 10);
            e_rd   = (r >= 1) && (r <= 10);
            e_idx  = e_ks ? 4'(k) : (e_rd ? 4'(r) : 4'd0);
            e_last = e_rd && (r == 10);
            check("proc", {in_ready, dp_load, cache_hit, busy, dp_key_step, dp_round_en,
                           dp_idx, dp_last_round, out_valid},
                          {1'b0, 1'b0, 1'b0, 1'b1, e_ks, e_rd, e_idx, e_last, 1'b0});
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            key_flush = 1'b0;
            out_ready = 1'b0;
            #1;
            check("done_hold", {out_valid, in_ready, busy, blk_cnt},
                               {1'b1, 1'b0, 1'b1, exp_cnt});
        end
        @(negedge clk);
        in_valid  = 1'b0;
        key_flush = 1'b0;
        out_ready = 1'b1;
        #1;
        check("done_hs", {out_valid, in_ready, dp_idx, dp_round_en, blk_cnt},
                         {1'b1, 1'b0, 4'd0, 1'b0, exp_cnt});
        @(negedge clk);
        out_ready = 1'b0;
        exp_cnt   = exp_cnt + 1'b1;
        #1;
        idle_check("idle_after");
    endtask

    logic [127:0] k0;
    logic [127:0] k1;
    logic [127:0] k2;

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        exp_cnt   = '0;
        k0        = 128'h000102030405060708090a0b0c0d0e0f;
        k1        = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        k2        = 128'hffeeddccbbaa99887766554433221100;
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_key    = '0;
        out_ready = 1'b0;
        key_flush = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        idle_check("in_reset");
        @(negedge clk);
        resetn = 1'b1;
        #1;
        idle_check("reset_rel");

        run_block(k0, 1'b0, 1'b0, 0, 1'b0, 0);        // first request: full expansion
        run_block(k0, 1'b0, CACHE_ON, 5, 1'b1, 0);    // repeat key, stalled consumer, ignored noise
        run_block(k0, 1'b1, 1'b0, 0, 1'b0, 0);        // flush with accept forces miss
        run_block(k0, 1'b0, CACHE_ON, 0, 1'b0, 0);
        run_block(k1, 1'b0, 1'b0, 0, 1'b0, 10);       // flush on final expansion cycle
        run_block(k1, 1'b0, 1'b0, 0, 1'b0, 0);
        run_block(k1, 1'b0, CACHE_ON, 0, 1'b0, 0);

        // Reset in the middle of a block
        @(negedge clk);
        in_valid = 1'b1;
        in_key   = k2;
        #1;
        check("mid_accept", {dp_load, cache_hit}, {1'b1, 1'b0});
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        #1;
        check("mid_round", {dp_round_en, dp_idx}, {1'b1, 4'd4});
        @(negedge clk);
        resetn  = 1'b0;
        exp_cnt = '0;
        #1;
        idle_check("mid_reset");
        @(negedge clk);
        resetn = 1'b1;
        #1;
        idle_check("mid_release");
        run_block(k2, 1'b0, 1'b0, 0, 1'b0, 0);        // cache lost across reset

        for (int i = 0; i < 16; i++) begin
            run_block(k2, 1'b0, CACHE_ON, 0, 1'b0, 0);
        end
        check("wrap", {28'd0, blk_cnt}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes128_seq.md
AES128_SEQ -- requirements
Module: aes128_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the completed-block counter.
REQ-002 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-004 SHALL have in_valid  in  1 (block request) and in_ready  out  1 (controller can accept).
REQ-005 SHALL have in_key  in  128  cipher key presented with the request, sampled only on accept.
REQ-006 SHALL have out_valid  out  1 (ciphertext ready in datapath) and out_ready  in  1 (consumer takes it).
REQ-007 SHALL have key_flush  in  1  invalidates the cached key.
REQ-008 SHALL have dp_load  out  1  datapath captures data^key and round key 0.
REQ-009 SHALL have dp_key_step  out  1  datapath computes and stores one expanded round key.
REQ-010 SHALL have dp_round_en  out  1  datapath executes one cipher round.
REQ-011 SHALL have dp_idx  out  4  round-key/round index, 1..10.
REQ-012 SHALL have dp_last_round  out  1  final round (no MixColumns), high only when dp_round_en and dp_idx==10.
REQ-013 SHALL have busy, cache_hit  out  1 each, and blk_cnt  out  CNT_W  completed-block count.

Function
REQ-014 SHALL implement states IDLE, KEYEXP, ROUND, DONE; in_ready=1 only in IDLE.
REQ-015 Accept = in_valid && in_ready; dp_load SHALL equal accept combinationally (cycle T).
REQ-016 On accept with cache miss SHALL go KEYEXP: cycles T+1..T+10 dp_key_step=1, dp_idx=1..10.
REQ-017 After KEYEXP (or directly after accept on cache hit) SHALL go ROUND: 10 cycles dp_round_en=1, dp_idx=1..10.
REQ-018 After ROUND SHALL enter DONE with out_valid=1: miss at T+21, hit at T+11.
REQ-019 out_valid SHALL hold until out_ready; on out_valid && out_ready SHALL return to IDLE next cycle and increment blk_cnt.
REQ-020 blk_cnt SHALL wrap from all-ones to 0.
REQ-021 busy SHALL be 1 in KEYEXP, ROUND, DONE; dp_idx SHALL be 0 whenever no dp_key_step/dp_round_en.
REQ-022 No new request SHALL be accepted before DONE completes (no overlap); out_ready outside DONE SHALL be ignored.
REQ-023 cache_hit SHALL pulse for the accept cycle only, when the request hits.

Reset
REQ-024 resetn low SHALL force IDLE immediately: in_ready=1 after release, all other outputs 0, blk_cnt=0, cache invalid.
REQ-025 Reset mid-operation SHALL abandon the block without out_valid and without counting it.

Configuration
REQ-026 With AES_KEY_CACHE_EN defined: last fully expanded key SHALL be stored (with valid bit set on final KEYEXP cycle); accept with valid && in_key==stored SHALL be a hit.
REQ-027 key_flush SHALL clear the valid bit; flush coincident with accept SHALL make that accept a miss; flush during final KEYEXP cycle SHALL win (valid stays 0).
REQ-028 Without AES_KEY_CACHE_EN: every accept is a miss, cache_hit tied 0, key_flush and key storage absent.

Structure
REQ-029 Shared package aes_pkg SHALL hold state enum, NR=10, round-index width 4.
REQ-030 Key compare/store SHALL be sub-module aes_key_cache, instantiated only under AES_KEY_CACHE_EN.

Verification
REQ-031 Key 000102..0f, first request -> dp_key_step T+1..T+10 idx 1..10, rounds T+11..T+20, dp_last_round at T+20, out_valid T+21.
REQ-032 Same key again (cache on) -> cache_hit at T, no dp_key_step, out_valid at T+11; cache off -> latency 21.
REQ-033 key_flush with accept of same key -> miss, latency 21.
REQ-034 out_ready held 0 for 5 cycles in DONE -> out_valid stays 1, in_ready 0, blk_cnt unchanged until handshake.
REQ-035 resetn low at T+15 -> all outputs 0, IDLE, blk_cnt 0, next same-key request is a miss.
REQ-036 CNT_W=4, 17 completed blocks -> blk_cnt = 1.
